x_mem_arbiter: RTL and testbench

//   Two-requester round-robin arbiter sharing one memory port that uses the rv32i core bus protocol
//   (valid/rnw/addr/data held until a one-cycle accept; read data returned in the accept cycle).

---
 rtl/x_mem_arbiter.sv | 120 ++++++++++++
 tb/tb_x_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_mem_arbiter.sv
// Two-master round-robin arbiter onto one rv32i-style memory port.
// A per-grant watchdog completes a stalled transfer with ERR_DATA and sets a sticky error.
module x_mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_r0_valid,
  input  logic          i_r0_rnw,
  input  logic [AW-1:0] i_r0_addr,
  input  logic [DW-1:0] i_r0_data,
  output logic          o_r0_accept,
  output logic [DW-1:0] o_r0_data,
  input  logic          i_r1_valid,
  input  logic          i_r1_rnw,
  input  logic [AW-1:0] i_r1_addr,
  input  logic [DW-1:0] i_r1_data,
  output logic          o_r1_accept,
  output logic [DW-1:0] o_r1_data,
  output logic          o_m_valid,
  output logic          o_m_rnw,
  output logic [AW-1:0] o_m_addr,
  output logic [DW-1:0] o_m_data,
  input  logic          i_m_accept,
  input  logic [DW-1:0] i_m_data,
  output logic [1:0]    o_grant,
  output logic          o_err
);
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  localparam bit WD_EN = (TIMEOUT > 0);
  localparam int WDW = WD_EN ? $clog2(TIMEOUT + 1) : 1;
  // The timeout cycle is the TIMEOUT-th grant cycle without an accept.
  localparam logic [WDW-1:0] WD_LAST = WD_EN ? WDW'(TIMEOUT - 1) : '0;

  state_t         state, state_nx;
  logic           last;
  logic [WDW-1:0] wd;
  logic           err;
  logic           busy, own1, own_valid, oth_valid, done, abort, tout;

  assign busy      = (state != IDLE);
  assign own1      = (state == GNT1);
  assign own_valid = own1 ? i_r1_valid : i_r0_valid;
  assign oth_valid = own1 ? i_r0_valid : i_r1_valid;
  assign abort     = busy && !own_valid;
  assign done      = busy && own_valid && i_m_accept;
  assign tout      = WD_EN && busy && own_valid && !i_m_accept && (wd == WD_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (i_r0_valid && (!i_r1_valid || last)) state_nx = GNT0;
        else if (i_r1_valid)                     state_nx = GNT1;
      end
      GNT0, GNT1: begin
        if (abort || tout) state_nx = IDLE;
        else if (done)     state_nx = !oth_valid ? IDLE : (own1 ? GNT0 : GNT1);
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last <= 1'b1;
      wd   <= '0;
      err  <= 1'b0;
    end else begin
      if (done || tout) last <= own1;
      if (WD_EN && busy && own_valid && !i_m_accept && !tout) wd <= wd + 1'b1;
      else                                                   wd <= '0;
      if (tout) err <= 1'b1;
    end
  end

  always_comb begin
    o_m_valid   = 1'b0;
    o_m_rnw     = 1'b1;
    o_m_addr    = '0;
    o_m_data    = '0;
    o_r0_accept = 1'b0;
    o_r0_data   = '0;
    o_r1_accept = 1'b0;
    o_r1_data   = '0;
    o_grant     = 2'b00;
    case (state)
      GNT0: begin
        o_m_valid   = i_r0_valid && !tout;
        o_m_rnw     = i_r0_rnw;
        o_m_addr    = i_r0_addr;
        o_m_data    = i_r0_data;
        o_r0_accept = done || tout;
        o_r0_data   = tout ? ERR_DATA : i_m_data;
        o_grant     = 2'b01;
      end
      GNT1: begin
        o_m_valid   = i_r1_valid && !tout;
        o_m_rnw     = i_r1_rnw;
        o_m_addr    = i_r1_addr;
        o_m_data    = i_r1_data;
        o_r1_accept = done || tout;
        o_r1_data   = tout ? ERR_DATA : i_m_data;
        o_grant     = 2'b10;
      end
      default: ;
    endcase
  end

  assign o_err = err;
endmodule

// File: tb/tb_x_mem_arbiter.sv
// Bench for x_mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level round-robin/watchdog model.
module tb_x_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_r0_valid, i_r0_rnw, i_r1_valid, i_r1_rnw, i_m_accept;
  logic [AW-1:0] i_r0_addr, i_r1_addr;
  logic [DW-1:0] i_r0_data, i_r1_data, i_m_data;
  logic          o_r0_accept, o_r1_accept, o_m_valid, o_m_rnw, o_err;
  logic [DW-1:0] o_r0_data, o_r1_data, o_m_data;
  logic [AW-1:0] o_m_addr;
  logic [1:0]    o_grant;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  x_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_r0_valid(i_r0_valid), .i_r0_rnw(i_r0_rnw), .i_r0_addr(i_r0_addr), .i_r0_data(i_r0_data),
    .o_r0_accept(o_r0_accept), .o_r0_data(o_r0_data),
    .i_r1_valid(i_r1_valid), .i_r1_rnw(i_r1_rnw), .i_r1_addr(i_r1_addr), .i_r1_data(i_r1_data),
    .o_r1_accept(o_r1_accept), .o_r1_data(o_r1_data),
    .o_m_valid(o_m_valid), .o_m_rnw(o_m_rnw), .o_m_addr(o_m_addr), .o_m_data(o_m_data),
    .i_m_accept(i_m_accept), .i_m_data(i_m_data),
    .o_grant(o_grant), .o_err(o_err)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_r0_valid = 0; i_r0_rnw = 1; i_r0_addr = '0; i_r0_data = '0;
    i_r1_valid = 0; i_r1_rnw = 1; i_r1_addr = '0; i_r1_data = '0;
    i_m_accept = 0; i_m_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst = 1;
    step();
    step();
    i_rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1;
    #3;
    checks++;
    if ({o_m_valid, o_m_rnw, o_r0_accept, o_r1_accept, o_grant, o_err} !== 7'b0100000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0100000",
               {o_m_valid, o_m_rnw, o_r0_accept, o_r1_accept, o_grant, o_err});
    end
    checks++;
    if ((o_m_addr | o_m_data | o_r0_data | o_r1_data) !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h mdata=%h d0=%h d1=%h exp=0",
               o_m_addr, o_m_data, o_r0_data, o_r1_data);
    end
    step();
    step();
    i_rst = 0;
  endtask

  task automatic test_single_read();
    i_r0_valid = 1; i_r0_rnw = 1; i_r0_addr = 32'h100;
    @(negedge i_clk);
    checks++;
    if ({o_grant, o_m_valid} !== 3'b000) begin
      failures++; $display("FAIL t1_latency got grant=%b mv=%b exp=00/0", o_grant, o_m_valid);
    end
    step(); @(negedge i_clk);
    checks++;
    if ({o_grant, o_m_valid, o_m_rnw, o_r0_accept} !== 5'b01110 || o_m_addr !== 32'h100) begin
      failures++;
      $display("FAIL t1_grant got grant=%b mv=%b rnw=%b acc=%b addr=%h exp=01/1/1/0/100",
               o_grant, o_m_valid, o_m_rnw, o_r0_accept, o_m_addr);
    end
    step();
    step();
    i_m_accept = 1; i_m_data = 32'h12345678;
    @(negedge i_clk);
    checks++;
    if (o_r0_accept !== 1'b1 || o_r0_data !== 32'h12345678) begin
      failures++; $display("FAIL t1_accept got acc=%b data=%h exp=1/12345678", o_r0_accept, o_r0_data);
    end
    step();
    i_m_accept = 0; i_r0_valid = 0;
    @(negedge i_clk);
    checks++;
    if ({o_r0_accept, o_grant} !== 3'b000) begin
      failures++; $display("FAIL t1_done got acc=%b grant=%b exp=0/00", o_r0_accept, o_grant);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    i_r0_valid = 1; i_r0_rnw = 1; i_r0_addr = 32'h200;
    i_r1_valid = 1; i_r1_rnw = 0; i_r1_addr = 32'h300; i_r1_data = 32'hA5A5A5A5;
    step();
    i_m_accept = 1; i_m_data = 32'h0BADF00D;
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b01 || o_r0_accept !== 1'b1 || o_r1_accept !== 1'b0 || o_r0_data !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL t2_first got grant=%b a0=%b a1=%b d0=%h exp=01/1/0/0badf00d",
               o_grant, o_r0_accept, o_r1_accept, o_r0_data);
    end
    step();
    i_r0_valid = 0;
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b10 || o_m_valid !== 1'b1 || o_m_rnw !== 1'b0 ||
        o_m_addr !== 32'h300 || o_m_data !== 32'hA5A5A5A5 || o_r1_accept !== 1'b1) begin
      failures++;
      $display("FAIL t2_second got grant=%b mv=%b rnw=%b addr=%h data=%h a1=%b exp=10/1/0/300/a5a5a5a5/1",
               o_grant, o_m_valid, o_m_rnw, o_m_addr, o_m_data, o_r1_accept);
    end
    step();
    i_r1_valid = 0; i_m_accept = 0;
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b00) begin
      failures++; $display("FAIL t2_idle got grant=%b exp=00", o_grant);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    i_r0_valid = 1; i_r0_addr = 32'h10;
    i_r1_valid = 1; i_r1_addr = 32'h20;
    i_m_accept = 1; i_m_data = 32'h77;
    step();
    exp_g = 2'b01;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      checks++;
      if (o_grant !== exp_g || {o_r1_accept, o_r0_accept} !== exp_g) begin
        failures++;
        $display("FAIL t3_alt%0d got grant=%b acc=%b%b exp=%b", k, o_grant, o_r1_accept, o_r0_accept, exp_g);
      end
      exp_g = ~exp_g;
      step();
    end
    i_r0_valid = 0; i_r1_valid = 0; i_m_accept = 0;
    step();
  endtask

  task automatic test_timeout();
    i_r1_valid = 1; i_r1_rnw = 1; i_r1_addr = 32'h400;
    step();
    for (int c = 1; c <= TO; c++) begin
      @(negedge i_clk);
      checks++;
      if (c < TO) begin
        if (o_r1_accept !== 1'b0 || o_m_valid !== 1'b1) begin
          failures++; $display("FAIL t4_wait%0d got acc=%b mv=%b exp=0/1", c, o_r1_accept, o_m_valid);
        end
        step();
      end else begin
        if (o_r1_accept !== 1'b1 || o_r1_data !== ERRD || o_m_valid !== 1'b0) begin
          failures++;
          $display("FAIL t4_fire got acc=%b data=%h mv=%b exp=1/deadbeef/0", o_r1_accept, o_r1_data, o_m_valid);
        end
      end
    end
    step();
    i_r1_valid = 0;
    @(negedge i_clk);
    checks++;
    if (o_err !== 1'b1 || o_grant !== 2'b00 || o_r1_accept !== 1'b0) begin
      failures++; $display("FAIL t4_err got err=%b grant=%b acc=%b exp=1/00/0", o_err, o_grant, o_r1_accept);
    end
    i_r0_valid = 1; i_r0_rnw = 1; i_r0_addr = 32'h500;
    step();
    i_m_accept = 1; i_m_data = 32'h55AA55AA;
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b01 || o_r0_accept !== 1'b1 || o_r0_data !== 32'h55AA55AA || o_err !== 1'b1) begin
      failures++;
      $display("FAIL t4_next got grant=%b acc=%b data=%h err=%b exp=01/1/55aa55aa/1",
               o_grant, o_r0_accept, o_r0_data, o_err);
    end
    step();
    i_r0_valid = 0; i_m_accept = 0;
    step();
    checks++;
    if (o_err !== 1'b1) begin
      failures++; $display("FAIL t4_sticky got err=%b exp=1", o_err);
    end
  endtask

  task automatic test_timeout_race();
    do_reset();
    i_r0_valid = 1; i_r0_rnw = 0; i_r0_addr = 32'h600; i_r0_data = 32'h1;
    step();
    step(); step(); step();
    i_m_accept = 1; i_m_data = 32'h0000CAFE;
    @(negedge i_clk);
    checks++;
    if (o_r0_accept !== 1'b1 || o_r0_data !== 32'h0000CAFE || o_m_valid !== 1'b1) begin
      failures++;
      $display("FAIL t5_race got acc=%b data=%h mv=%b exp=1/0000cafe/1", o_r0_accept, o_r0_data, o_m_valid);
    end
    step();
    i_r0_valid = 0; i_m_accept = 0;
    @(negedge i_clk);
    checks++;
    if (o_err !== 1'b0 || o_grant !== 2'b00) begin
      failures++; $display("FAIL t5_noerr got err=%b grant=%b exp=0/00", o_err, o_grant);
    end
  endtask

  task automatic test_reset_mid();
    i_r0_valid = 1; i_r0_rnw = 1; i_r0_addr = 32'h700;
    step();
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b01) begin
      failures++; $display("FAIL t6_pre got grant=%b exp=01", o_grant);
    end
    step();
    i_rst = 1;
    #1;
    checks++;
    if ({o_m_valid, o_grant, o_r0_accept} !== 4'b0000) begin
      failures++;
      $display("FAIL t6_async got mv=%b grant=%b acc=%b exp=0/00/0", o_m_valid, o_grant, o_r0_accept);
    end
    step();
    i_rst = 0;
    @(negedge i_clk);
    checks++;
    if ({o_grant, o_r0_accept} !== 3'b000) begin
      failures++; $display("FAIL t6_release got grant=%b acc=%b exp=00/0", o_grant, o_r0_accept);
    end
    step();
    @(negedge i_clk);
    checks++;
    if (o_grant !== 2'b01 || o_m_addr !== 32'h700) begin
      failures++; $display("FAIL t6_regrant got grant=%b addr=%h exp=01/700", o_grant, o_m_addr);
    end
    step();
    i_r0_valid = 0;
    step();
  endtask

  task automatic test_random();
    int owner, cnt, x;
    bit last, err_m, tmo, macc;
    bit pend[2];
    bit rnw[2];
    logic [31:0] addr[2], wdat[2];
    logic [31:0] mdata, e_addr, e_wd, e_d0, e_d1;
    logic [1:0] e_grant, e_acc;
    bit e_mv;
    do_reset();
    owner = -1; cnt = 0; last = 1; err_m = 0;
    pend[0] = 0; pend[1] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(1, 0) == 1) begin
          pend[r] = 1; rnw[r] = 1'($urandom_range(1, 0)); addr[r] = $urandom; wdat[r] = $urandom;
        end
      end
      macc = ($urandom_range(9, 0) < 4);
      mdata = $urandom;
      i_r0_valid = pend[0]; i_r0_rnw = rnw[0]; i_r0_addr = addr[0]; i_r0_data = wdat[0];
      i_r1_valid = pend[1]; i_r1_rnw = rnw[1]; i_r1_addr = addr[1]; i_r1_data = wdat[1];
      i_m_accept = macc; i_m_data = mdata;

      e_grant = 2'b00; e_mv = 0; e_addr = '0; e_wd = '0; e_acc = 2'b00; e_d0 = '0; e_d1 = '0; tmo = 0;
      if (owner >= 0) begin
        tmo = !macc && (cnt + 1 == TO);
        e_grant = (owner == 0) ? 2'b01 : 2'b10;
        e_mv = !tmo;
        e_addr = addr[owner];
        e_wd = wdat[owner];
        e_acc = (macc || tmo) ? e_grant : 2'b00;
        if (owner == 0) e_d0 = tmo ? ERRD : mdata;
        else            e_d1 = tmo ? ERRD : mdata;
      end

      @(negedge i_clk);
      checks++;
      if (o_grant !== e_grant || o_m_valid !== e_mv) begin
        failures++;
        $display("FAIL rnd%0d_grant got grant=%b mv=%b exp=%b/%b", n, o_grant, o_m_valid, e_grant, e_mv);
      end
      checks++;
      if ({o_r1_accept, o_r0_accept} !== e_acc || o_r0_data !== e_d0 || o_r1_data !== e_d1) begin
        failures++;
        $display("FAIL rnd%0d_resp got acc=%b%b d0=%h d1=%h exp=%b d0=%h d1=%h",
                 n, o_r1_accept, o_r0_accept, o_r0_data, o_r1_data, e_acc, e_d0, e_d1);
      end
      if (e_mv) begin
        checks++;
        if (o_m_addr !== e_addr || o_m_data !== e_wd) begin
          failures++;
          $display("FAIL rnd%0d_bus got addr=%h data=%h exp=%h/%h", n, o_m_addr, o_m_data, e_addr, e_wd);
        end
      end
      checks++;
      if (o_err !== err_m) begin
        failures++; $display("FAIL rnd%0d_err got err=%b exp=%b", n, o_err, err_m);
      end

      if (owner < 0) begin
        if (pend[0] && (!pend[1] || last)) owner = 0;
        else if (pend[1])                  owner = 1;
      end else if (macc || tmo) begin
        x = owner;
        last = (x == 1);
        cnt = 0;
        pend[x] = 0;
        if (tmo) err_m = 1;
        owner = (macc && pend[1 - x]) ? 1 - x : -1;
      end else begin
        cnt++;
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    i_rst = 1;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_alternate();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
